// File: rtl/morph_filter.sv
// Two-stage 1-D grayscale morphology filter (erode/dilate/open/close) on AXI-Stream.
// Valid/ready: a transfer happens on a rising edge where tvalid && tready; tdata is held while tvalid && !tready.
module morph_stage #(
    parameter int DW  = 16,
    parameter int KW  = 71,
    parameter int KDW = 8,
    parameter int IW  = 17,
    parameter int AW  = $clog2(KW)
) (
    input  logic           clk,
    input  logic           areset_n,
    input  logic           clear,
    input  logic           bypass,
    input  logic           erode,
    input  logic [DW-1:0]  in_tdata,
    input  logic           in_tvalid,
    output logic           in_tready,
    output logic [DW-1:0]  out_tdata,
    output logic           out_tvalid,
    input  logic           out_tready,
    output logic [AW-1:0]  lut_address,
    input  logic [KDW-1:0] lut_data,
    output logic [1:0]     dbg_state
);
    localparam int CW = $clog2(KW + 1);
    localparam logic signed [IW-1:0] MAXV = {{(IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_OUT = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [IW-1:0] acc_q, acc_d;
    logic [DW-1:0]        out_q, out_d;
    logic                 full_q, full_d;
    logic [DW-1:0]        win_q [KW];
    logic [DW-1:0]        win_d [KW];

    logic [AW-1:0]        idx;
    logic [DW-1:0]        w_sel;
    logic signed [IW-1:0] w_ext, k_ext, term, folded;
    logic [DW-1:0]        sat;
    logic                 accept;

    assign in_tready   = bypass ? (!full_q || out_tready) : (state_q == S_IDLE);
    assign out_tvalid  = bypass ? full_q : (state_q == S_OUT);
    assign out_tdata   = out_q;
    assign accept      = in_tvalid && in_tready;
    assign dbg_state   = state_q;
    assign lut_address = (state_q == S_CALC && cnt_q < CW'(KW)) ? AW'(cnt_q) : '0;

    // Count c >= 1 folds the coefficient fetched for address c-1 on the previous cycle.
    always_comb begin
        idx    = (cnt_q == '0) ? '0 : AW'(cnt_q - CW'(1));
        w_sel  = win_q[idx];
        w_ext  = {{(IW-DW){w_sel[DW-1]}}, w_sel};
        k_ext  = {{(IW-KDW){lut_data[KDW-1]}}, lut_data};
        term   = erode ? (w_ext - k_ext) : (w_ext + k_ext);
        folded = acc_q;
        if (cnt_q == CW'(1))
            folded = term;
        else if (erode ? (term < acc_q) : (term > acc_q))
            folded = term;
        if (folded > MAXV)
            sat = MAXV[DW-1:0];
        else if (folded < MINV)
            sat = MINV[DW-1:0];
        else
            sat = folded[DW-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out_q;
        full_d  = full_q;
        win_d   = win_q;
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            out_d   = '0;
            full_d  = 1'b0;
            for (int k = 0; k < KW; k++) win_d[k] = '0;
        end else if (bypass) begin
            if (accept) begin
                full_d = 1'b1;
                out_d  = in_tdata;
            end else if (out_tready) begin
                full_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        win_d[0] = in_tdata;
                        for (int k = 1; k < KW; k++) win_d[k] = win_q[k-1];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q != '0) acc_d = folded;
                    if (cnt_q == CW'(KW)) begin
                        out_d   = sat;
                        cnt_d   = '0;
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_tready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            full_q  <= 1'b0;
            for (int k = 0; k < KW; k++) win_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            full_q  <= full_d;
            win_q   <= win_d;
        end
    end
endmodule

module morph_filter #(
    parameter int         DATA_WIDTH        = 16,
    parameter int         KERNEL_WIDTH      = 71,
    parameter int         KERNEL_DATA_WIDTH = 8,
    parameter int         INTERNAL_WIDTH    = 17,
    parameter logic [1:0] DEFAULT_MODE      = 2'b10
) (
    input  logic                            clk,
    input  logic                            areset_n,
    input  logic [DATA_WIDTH-1:0]           axis_in_tdata,
    input  logic                            axis_in_tvalid,
    output logic                            axis_in_tready,
    output logic [DATA_WIDTH-1:0]           axis_out_tdata,
    output logic                            axis_out_tvalid,
    input  logic                            axis_out_tready,
    input  logic [1:0]                      mode,
    input  logic                            clear,
    output logic [$clog2(KERNEL_WIDTH)-1:0] k1_lut_address,
    input  logic [KERNEL_DATA_WIDTH-1:0]    k1_lut_data,
    output logic [$clog2(KERNEL_WIDTH)-1:0] k2_lut_address,
    input  logic [KERNEL_DATA_WIDTH-1:0]    k2_lut_data,
    output logic [1:0]                      dbg_s1_state,
    output logic [1:0]                      dbg_s2_state
);
    localparam int AW = $clog2(KERNEL_WIDTH);

    logic [1:0]            mode_q, mode_d;
    logic                  init_q, init_d;
    logic                  s1_in_tready;
    logic [DATA_WIDTH-1:0] s1_tdata;
    logic                  s1_tvalid, s2_in_tready;

    // init_q holds input ready low until the first clock edge after reset.
    always_comb begin
        mode_d = clear ? mode : mode_q;
        init_d = 1'b1;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            mode_q <= DEFAULT_MODE;
            init_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            init_q <= init_d;
        end
    end

    assign axis_in_tready = s1_in_tready && init_q;

    // Stage 1 erodes for ERODE/OPEN; stage 2 bypasses for ERODE/DILATE and erodes for CLOSE.
    morph_stage #(
        .DW(DATA_WIDTH), .KW(KERNEL_WIDTH), .KDW(KERNEL_DATA_WIDTH),
        .IW(INTERNAL_WIDTH), .AW(AW)
    ) u_stage1 (
        .clk        (clk),
        .areset_n   (areset_n),
        .clear      (clear),
        .bypass     (1'b0),
        .erode      (!mode_q[0]),
        .in_tdata   (axis_in_tdata),
        .in_tvalid  (axis_in_tvalid && init_q),
        .in_tready  (s1_in_tready),
        .out_tdata  (s1_tdata),
        .out_tvalid (s1_tvalid),
        .out_tready (s2_in_tready),
        .lut_address(k1_lut_address),
        .lut_data   (k1_lut_data),
        .dbg_state  (dbg_s1_state)
    );

    morph_stage #(
        .DW(DATA_WIDTH), .KW(KERNEL_WIDTH), .KDW(KERNEL_DATA_WIDTH),
        .IW(INTERNAL_WIDTH), .AW(AW)
    ) u_stage2 (
        .clk        (clk),
        .areset_n   (areset_n),
        .clear      (clear),
        .bypass     (!mode_q[1]),
        .erode      (mode_q[0]),
        .in_tdata   (s1_tdata),
        .in_tvalid  (s1_tvalid),
        .in_tready  (s2_in_tready),
        .out_tdata  (axis_out_tdata),
        .out_tvalid (axis_out_tvalid),
        .out_tready (axis_out_tready),
        .lut_address(k2_lut_address),
        .lut_data   (k2_lut_data),
        .dbg_state  (dbg_s2_state)
    );
endmodule

// File: tb/tb_morph_filter.sv
// Self-checking bench for morph_filter with KW=3: directed cases plus randomized
// stimulus against a window/kernel reference model.
module tb_morph_filter;
    localparam int DW  = 16;
    localparam int KW  = 3;
    localparam int KDW = 8;
    localparam int IW  = 17;
    localparam int AW  = $clog2(KW);
    localparam int MAXI = (1 << (DW - 1)) - 1;
    localparam int MINI = -(1 << (DW - 1));

    logic           clk = 1'b0;
    logic           areset_n = 1'b0;
    logic [DW-1:0]  axis_in_tdata = '0;
    logic           axis_in_tvalid = 1'b0;
    logic           axis_in_tready;
    logic [DW-1:0]  axis_out_tdata;
    logic           axis_out_tvalid;
    logic           axis_out_tready = 1'b1;
    logic [1:0]     mode = 2'b10;
    logic           clear = 1'b0;
    logic [AW-1:0]  k1_lut_address, k2_lut_address;
    logic [KDW-1:0] k1_lut_data, k2_lut_data;
    logic [1:0]     dbg_s1_state, dbg_s2_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_valid_cyc = 0;
    bit seen_valid = 1'b0;

    int kern1[KW];
    int kern2[KW];
    logic [1:0] m_mode;
    int m_w1[$];
    int m_w2[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    morph_filter #(
        .DATA_WIDTH(DW), .KERNEL_WIDTH(KW), .KERNEL_DATA_WIDTH(KDW),
        .INTERNAL_WIDTH(IW), .DEFAULT_MODE(2'b10)
    ) dut (
        .clk(clk), .areset_n(areset_n),
        .axis_in_tdata(axis_in_tdata), .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .mode(mode), .clear(clear),
        .k1_lut_address(k1_lut_address), .k1_lut_data(k1_lut_data),
        .k2_lut_address(k2_lut_address), .k2_lut_data(k2_lut_data),
        .dbg_s1_state(dbg_s1_state), .dbg_s2_state(dbg_s2_state)
    );

    // Clock/reset and LUT memories with one-cycle read latency
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        k1_lut_data <= KDW'(kern1[k1_lut_address]);
        k2_lut_data <= KDW'(kern2[k2_lut_address]);
    end

    // Output monitor: records every completed output transfer
    always @(negedge clk) begin
        if (axis_out_tvalid && !seen_valid) begin
            seen_valid = 1'b1;
            first_valid_cyc = cyc;
        end
        if (axis_out_tvalid && axis_out_tready) got_q.push_back(axis_out_tdata);
    end

    // Reference model: each stage is a min/max over its last KW inputs with the kernel applied.
    function automatic int apply_stage(input int s, input bit erode);
        int r, t, w, k;
        r = 0;
        for (int i = 0; i < KW; i++) begin
            w = (s == 1) ? m_w1[i] : m_w2[i];
            k = (s == 1) ? kern1[i] : kern2[i];
            t = erode ? (w - k) : (w + k);
            if (i == 0 || (erode && t < r) || (!erode && t > r)) r = t;
        end
        if (r > MAXI) r = MAXI;
        if (r < MINI) r = MINI;
        return r;
    endfunction

    function automatic void model_reset(input logic [1:0] m);
        m_mode = m;
        m_w1.delete();
        m_w2.delete();
        for (int i = 0; i < KW; i++) begin
            m_w1.push_back(0);
            m_w2.push_back(0);
        end
    endfunction

    function automatic void model_in(input int x);
        int y;
        m_w1.push_front(x);
        void'(m_w1.pop_back());
        case (m_mode)
            2'b00: y = apply_stage(1, 1'b1);
            2'b01: y = apply_stage(1, 1'b0);
            2'b10: y = apply_stage(1, 1'b1);
            default: y = apply_stage(1, 1'b0);
        endcase
        if (m_mode == 2'b10 || m_mode == 2'b11) begin
            m_w2.push_front(y);
            void'(m_w2.pop_back());
            y = apply_stage(2, m_mode == 2'b11);
        end
        exp_q.push_back(DW'(y));
    endfunction

    // Driver tasks
    task automatic send(input int x);
        int n;
        n = 0;
        axis_in_tdata = DW'(x);
        axis_in_tvalid = 1'b1;
        while (!axis_in_tready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!axis_in_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: input ready stayed %b, required 1", axis_in_tready);
            axis_in_tvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc = cyc - 1;
        axis_in_tvalid = 1'b0;
        model_in(x);
    endtask

    task automatic do_clear(input logic [1:0] m);
        mode = m;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset(m);
        got_q.delete();
        exp_q.delete();
        seen_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    task automatic set_kernels_random();
        for (int i = 0; i < KW; i++) begin
            kern1[i] = int'($urandom_range(0, 40)) - 20;
            kern2[i] = int'($urandom_range(0, 40)) - 20;
        end
    endtask

    function automatic int rand_sample();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return MAXI;
        if (r == 1) return MINI;
        return int'($urandom_range(0, 60000)) - 30000;
    endfunction

    // Tests
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (axis_in_tready !== 1'b0) begin errors++; $display("FAIL reset_in_tready: got %b want 0", axis_in_tready); end
        checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_out_tvalid: got %b want 0", axis_out_tvalid); end
        checks++; if (axis_out_tdata !== '0) begin errors++; $display("FAIL reset_out_tdata: got %0h want 0", axis_out_tdata); end
        checks++; if (k1_lut_address !== '0 || k2_lut_address !== '0) begin errors++; $display("FAIL reset_lut_addr: got %0d/%0d want 0/0", k1_lut_address, k2_lut_address); end
        areset_n = 1'b1;
        #1;
        checks++; if (axis_in_tready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge: got %b want 0", axis_in_tready); end
        @(posedge clk); #1;
        checks++; if (axis_in_tready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge: got %b want 1", axis_in_tready); end
    endtask

    task automatic test_open_default();
        int vals[5] = '{0, 0, 9, 0, 0};
        int a0;
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(vals[i]);
            if (i == 0) a0 = acc_cyc;
        end
        wait_out(5);
        checks++; if (first_valid_cyc - a0 != 2 * KW + 4) begin errors++; $display("FAIL open_latency: got %0d want %0d", first_valid_cyc - a0, 2 * KW + 4); end
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL open_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++; if (got_q[i] !== '0) begin errors++; $display("FAIL open_out[%0d]: got %0d want 0", i, $signed(got_q[i])); end
        end
    endtask

    task automatic test_erode();
        int vals[5] = '{5, 2, 7, 9, 8};
        int want[5] = '{0, 0, 2, 2, 7};
        int a0;
        for (int i = 0; i < KW; i++) begin kern1[i] = 0; kern2[i] = 0; end
        do_clear(2'b00);
        for (int i = 0; i < 5; i++) begin
            send(vals[i]);
            if (i == 0) a0 = acc_cyc;
        end
        wait_out(5);
        checks++; if (first_valid_cyc - a0 != KW + 3) begin errors++; $display("FAIL erode_latency: got %0d want %0d", first_valid_cyc - a0, KW + 3); end
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL erode_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++; if ($signed(got_q[i]) != want[i]) begin errors++; $display("FAIL erode_out[%0d]: got %0d want %0d", i, $signed(got_q[i]), want[i]); end
        end
    endtask

    task automatic test_dilate();
        int vals[5] = '{5, 2, 7, 9, 8};
        int want[5] = '{6, 5, 8, 10, 9};
        kern1[0] = 1; kern1[1] = 0; kern1[2] = 0;
        do_clear(2'b01);
        for (int i = 0; i < 5; i++) send(vals[i]);
        wait_out(5);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL dilate_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++; if ($signed(got_q[i]) != want[i]) begin errors++; $display("FAIL dilate_out[%0d]: got %0d want %0d", i, $signed(got_q[i]), want[i]); end
        end
    endtask

    task automatic test_saturation();
        kern1[0] = 5; kern1[1] = 0; kern1[2] = 0;
        do_clear(2'b01);
        repeat (3) send(MAXI);
        wait_out(3);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL sat_hi_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++; if ($signed(got_q[i]) != MAXI) begin errors++; $display("FAIL sat_hi[%0d]: got %0d want %0d", i, $signed(got_q[i]), MAXI); end
        end
        do_clear(2'b00);
        repeat (3) send(MINI);
        wait_out(3);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL sat_lo_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++; if ($signed(got_q[i]) != MINI) begin errors++; $display("FAIL sat_lo[%0d]: got %0d want %0d", i, $signed(got_q[i]), MINI); end
        end
    endtask

    task automatic test_close();
        int vals[8] = '{9, 9, 9, 9, 9, 0, 9, 9};
        int want[8] = '{0, 0, 9, 9, 9, 9, 9, 9};
        for (int i = 0; i < KW; i++) begin kern1[i] = 0; kern2[i] = 0; end
        do_clear(2'b11);
        for (int i = 0; i < 8; i++) send(vals[i]);
        wait_out(8);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL close_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            checks++; if ($signed(got_q[i]) != want[i]) begin errors++; $display("FAIL close_out[%0d]: got %0d want %0d", i, $signed(got_q[i]), want[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc[4];
        set_kernels_random();
        do_clear(2'b00);
        for (int i = 0; i < 4; i++) begin
            send(rand_sample());
            acc[i] = acc_cyc;
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if (acc[i] - acc[i-1] != KW + 3) begin errors++; $display("FAIL b2b_interval[%0d]: got %0d want %0d", i, acc[i] - acc[i-1], KW + 3); end
        end
        wait_out(4);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        bit stable, ready_low;
        set_kernels_random();
        do_clear(2'b10);
        axis_out_tready = 1'b0;
        send(rand_sample());
        send(rand_sample());
        repeat (KW + 6) begin @(posedge clk); #1; end
        held = axis_out_tdata;
        stable = axis_out_tvalid;
        ready_low = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!axis_out_tvalid || axis_out_tdata !== held) stable = 1'b0;
            if (axis_in_tready) ready_low = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold: tvalid=%b tdata=%0h want 1/%0h", axis_out_tvalid, axis_out_tdata, held); end
        checks++; if (!ready_low) begin errors++; $display("FAIL bp_in_ready: got 1 during stall want 0"); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_output: got %0d transfers want 0", got_q.size()); end
        axis_out_tready = 1'b1;
        send(rand_sample());
        wait_out(3);
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_out[%0d]: got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_clear_mid_calc();
        set_kernels_random();
        do_clear(2'b10);
        send(rand_sample());
        repeat (2) begin @(posedge clk); #1; end
        do_clear(2'b01);
        checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL clear_tvalid: got %b want 0", axis_out_tvalid); end
        checks++; if (axis_in_tready !== 1'b1) begin errors++; $display("FAIL clear_tready: got %b want 1", axis_in_tready); end
        for (int i = 0; i < 4; i++) send(rand_sample());
        wait_out(4);
        repeat (30) begin @(posedge clk); #1; end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL clear_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clear_out[%0d]: got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_random();
        bit done;
        for (int m = 0; m < 4; m++) begin
            set_kernels_random();
            do_clear(2'(m));
            mode = ~2'(m);
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 12; i++) send(rand_sample());
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        axis_out_tready = ($urandom_range(0, 3) != 0);
                        @(posedge clk); #1;
                    end
                end
            join
            axis_out_tready = 1'b1;
            wait_out(12);
            checks++; if (got_q.size() != 12) begin errors++; $display("FAIL rand_count_m%0d: got %0d want 12", m, got_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_out_m%0d[%0d]: got %0d want %0d", m, i, $signed(got_q[i]), $signed(exp_q[i])); end
            end
        end
    endtask

    initial begin
        model_reset(2'b10);
        test_reset();
        test_open_default();
        test_erode();
        test_dilate();
        test_saturation();
        test_close();
        test_back_to_back();
        test_backpressure();
        test_clear_mid_calc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/morph_filter.md
# morph_filter

Runtime-configurable 1-D grayscale morphology filter on an AXI-Stream sample path. It contains two cascaded min/max stages, each with its own structuring-element LUT port. A latched mode selects one of four operations: erosion, dilation, opening (erode then dilate) or closing (dilate then erode). It replaces fixed single-operation chains in the filter pipeline and adds saturating arithmetic, a synchronous clear and stall-safe handshakes.

## Interface
- DATA_WIDTH, 16, signed sample width
- KERNEL_WIDTH, 71, structuring-element length (window depth per stage), ≥2
- KERNEL_DATA_WIDTH, 8, signed kernel coefficient width
- INTERNAL_WIDTH, 17, arithmetic width; must be ≥ max(DATA_WIDTH, KERNEL_DATA_WIDTH)+1
- DEFAULT_MODE, 2'b10, mode loaded at reset (OPEN)

Ports:
- clk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- axis_in_tdata  in  DATA_WIDTH  signed input sample
- axis_in_tvalid  in  1  input valid
- axis_in_tready  out  1  input ready
- axis_out_tdata  out  DATA_WIDTH  signed filtered sample
- axis_out_tvalid  out  1  output valid
- axis_out_tready  in  1  downstream ready
- mode  in  2  00 ERODE, 01 DILATE, 10 OPEN, 11 CLOSE; latched only on clear
- clear  in  1  synchronous flush plus mode load
- k1_lut_address / k2_lut_address  out  $clog2(KERNEL_WIDTH)  stage 1/2 kernel address
- k1_lut_data / k2_lut_data  in  KERNEL_DATA_WIDTH  signed coefficient; one-cycle read latency

## Operation
- Stage configuration by latched mode:
  - ERODE: stage1 erodes, stage2 bypasses.
  - DILATE: stage1 dilates, stage2 bypasses.
  - OPEN: stage1 erodes, stage2 dilates.
  - CLOSE: stage1 dilates, stage2 erodes.
- Each stage keeps a window w[0..KW-1] of its last KW accepted inputs, with w[0] the newest. Accepting a sample shifts the window. The window resets to 0.
- Erosion: y = min over k of (w[k] − K[k]). Dilation: y = max over k of (w[k] + K[k]).
- Operands are sign-extended to INTERNAL_WIDTH. The final result saturates to the signed DATA_WIDTH range.
- Stage FSM:
  - IDLE: in_tready=1. On accept, shift the window, clear the accumulator, go to CALC.
  - CALC: lasts KW+1 cycles. Addresses 0..KW-1 are issued in the first KW cycles. Data for address k is folded in on the following cycle. The first fold loads the accumulator directly. Then go to OUT.
  - OUT: tvalid=1 and tdata is held stable until tready; on tready go to IDLE.
- Bypass stage: a one-deep register slice. tready is high when empty or when the output is being consumed. k2_lut_address is held at 0.
- axis_in_tready is stage1's IDLE indication, and stage1 OUT feeds stage2's input. Throughput is one sample per KW+3 cycles at most.
- clear has priority over all handshakes. It zeros both windows and accumulators, sends both FSMs to IDLE, drops in-flight samples and loads mode. On the cycle after clear: tvalid=0, tready=1.
- Reset values: axis_in_tready=0 while areset_n is low and 1 after the first clock edge; axis_out_tvalid=0; axis_out_tdata=0; LUT addresses 0; mode=DEFAULT_MODE.
- A mode change without clear has no effect.

## Timing
- Accept at cycle 0 (input handshake). Stage1 enters OUT, with its tvalid first asserted, at cycle KW+2 (measured from the accept cycle, no stalls).
- ERODE/DILATE: axis_out_tvalid first asserted at cycle KW+3.
- OPEN/CLOSE: axis_out_tvalid first asserted at cycle 2·KW+4.
- Back-pressure: stalls propagate upstream with no loss or duplication. tdata holds while tvalid && !tready.
- Reset mid-CALC: all state is discarded immediately (asynchronous).

## Test plan
- ERODE, KW=3, kernel {0,0,0}, inputs 5,2,7,9,8 -> outputs 0,0,2,2,7; first tvalid at cycle 6 after the first accept.
- DILATE, KW=3, kernel {1,0,0}, inputs 5,2,7,9,8 -> outputs 6,5,8,10,9.
- Saturation, DATA_WIDTH=16: DILATE with K[0]=5 on a window of 32767s -> 32767. ERODE with K[0]=5 on a window of −32768s -> −32768.
- OPEN, KW=3, zero kernel, inputs 0,0,9,0,0 -> all outputs 0 (spike removed). CLOSE on 9,9,0,9,9 after a preload of 9s -> the 0 notch is filled to 9.
- Back-pressure: axis_out_tready low for 20 cycles with the output pending -> tdata stable, axis_in_tready drops once both stages are full, no sample lost after release.
- Clear mid-CALC with mode changed to DILATE -> next cycle tvalid=0 and tready=1, the in-flight sample is never output, subsequent samples are dilated against a zeroed window.
